// File: rtl/hxd32_pkg.sv
// Shared types for the hxd32 write-back path: register addresses and the
// write-back arbitration state encoding.
package hxd32_pkg;

   typedef logic [4:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_WAIT,
      WB_FORCE
   } wb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bits for in-flight MDU results, with three lookup ports
// for the decode-stage hazard check. Register x0 is never busy.
module wb_scoreboard
   import hxd32_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_n_i,
   input  logic      set_en_i,
   input  reg_addr_t set_rd_i,
   input  logic      clr_en_i,
   input  reg_addr_t clr_rd_i,
   input  reg_addr_t rs1_i,
   input  reg_addr_t rs2_i,
   input  reg_addr_t rd_i,
   output logic      busy_rs1_o,
   output logic      busy_rs2_o,
   output logic      busy_rd_o
);

   logic [31:0] r_busy;
   logic [31:0] w_busy_nxt;

   // NOTE: every combinational output gets its default first so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      w_busy_nxt = r_busy;
      if (clr_en_i)
         w_busy_nxt[clr_rd_i] = 1'b0;
      // Set is applied after clear so a back-to-back issue to the same rd wins.
      if (set_en_i && (set_rd_i != REG_ZERO))
         w_busy_nxt[set_rd_i] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign busy_rs1_o = r_busy[rs1_i];
   assign busy_rs2_o = r_busy[rs2_i];
   assign busy_rd_o  = r_busy[rd_i];

endmodule

// File: rtl/pipe_wb_ctl.sv
// Write-back port arbiter: pipeline has priority over the MDU, with a
// starvation counter that freezes the pipeline so a waiting MDU result drains.
module pipe_wb_ctl
   import hxd32_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            pipe_wr_en_i,
   input  reg_addr_t       pipe_rd_i,
   input  logic [XLEN-1:0] pipe_data_i,
   input  logic            mdu_valid_i,
   input  reg_addr_t       mdu_rd_i,
   input  logic [XLEN-1:0] mdu_data_i,
   output logic            mdu_ready_o,
   input  logic            iss_en_i,
   input  reg_addr_t       iss_rd_i,
   input  reg_addr_t       dec_rs1_i,
   input  reg_addr_t       dec_rs2_i,
   input  reg_addr_t       dec_rd_i,
   output logic            hazard_o,
   output logic            hold_o,
   output logic            rd_wr_en_o,
   output reg_addr_t       rd_wr_addr_o,
   output logic [XLEN-1:0] rd_wr_data_o
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   wb_state_t       r_state;
   wb_state_t       w_state_nxt;
   logic [3:0]      r_cnt;
   logic [3:0]      w_cnt_nxt;
   logic [3:0]      w_run;
   logic            r_hold;
   logic            r_wr_en;
   reg_addr_t       r_wr_addr;
   logic [XLEN-1:0] r_wr_data;
   logic            w_force;
   logic            w_pipe_gnt;
   logic            w_busy_rs1;
   logic            w_busy_rs2;
   logic            w_busy_rd;

   assign w_force     = (r_state == WB_FORCE);
   assign mdu_ready_o = mdu_valid_i & (w_force | ~pipe_wr_en_i);
   assign w_pipe_gnt  = pipe_wr_en_i & ~w_force;

   // Blocked cycles seen so far including this one; IDLE starts a fresh run.
   assign w_run = (r_state == WB_IDLE) ? 4'd1 : r_cnt + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!mdu_valid_i || mdu_ready_o) begin
         w_state_nxt = WB_IDLE;
         w_cnt_nxt   = 4'd0;
      end else begin
         case (r_state)
            WB_IDLE, WB_WAIT: begin
               if (w_run >= STARVE_LIM) begin
                  w_state_nxt = WB_FORCE;
                  w_cnt_nxt   = STARVE_LIM;
               end else begin
                  w_state_nxt = WB_WAIT;
                  w_cnt_nxt   = w_run;
               end
            end
            default: begin
               w_state_nxt = r_state;
               w_cnt_nxt   = r_cnt;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= WB_IDLE;
         r_cnt   <= 4'd0;
         r_hold  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hold  <= (w_state_nxt == WB_FORCE);
      end
   end

   // Address/data hold their last value when nobody is granted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= REG_ZERO;
         r_wr_data <= '0;
      end else if (w_pipe_gnt) begin
         r_wr_en   <= (pipe_rd_i != REG_ZERO);
         r_wr_addr <= pipe_rd_i;
         r_wr_data <= pipe_data_i;
      end else if (mdu_ready_o) begin
         r_wr_en   <= (mdu_rd_i != REG_ZERO);
         r_wr_addr <= mdu_rd_i;
         r_wr_data <= mdu_data_i;
      end else begin
         r_wr_en   <= 1'b0;
      end
   end

   wb_scoreboard u_scoreboard (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .set_en_i   (iss_en_i),
      .set_rd_i   (iss_rd_i),
      .clr_en_i   (mdu_ready_o),
      .clr_rd_i   (mdu_rd_i),
      .rs1_i      (dec_rs1_i),
      .rs2_i      (dec_rs2_i),
      .rd_i       (dec_rd_i),
      .busy_rs1_o (w_busy_rs1),
      .busy_rs2_o (w_busy_rs2),
      .busy_rd_o  (w_busy_rd)
   );

   assign hazard_o     = w_busy_rs1 | w_busy_rs2 | w_busy_rd;
   assign hold_o       = r_hold;
   assign rd_wr_en_o   = r_wr_en;
   assign rd_wr_addr_o = r_wr_addr;
   assign rd_wr_data_o = r_wr_data;

endmodule

// File: tb/tb_pipe_wb_ctl.sv
// Bench for pipe_wb_ctl: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of arbitration and busy bits.
module tb_pipe_wb_ctl;

   localparam int XLEN       = 32;
   localparam int STARVE_MAX = 4;

   logic            clk_i = 1'b0;
   logic            rst_n_i;
   logic            pipe_wr_en_i;
   logic [4:0]      pipe_rd_i;
   logic [XLEN-1:0] pipe_data_i;
   logic            mdu_valid_i;
   logic [4:0]      mdu_rd_i;
   logic [XLEN-1:0] mdu_data_i;
   logic            mdu_ready_o;
   logic            iss_en_i;
   logic [4:0]      iss_rd_i;
   logic [4:0]      dec_rs1_i;
   logic [4:0]      dec_rs2_i;
   logic [4:0]      dec_rd_i;
   logic            hazard_o;
   logic            hold_o;
   logic            rd_wr_en_o;
   logic [4:0]      rd_wr_addr_o;
   logic [XLEN-1:0] rd_wr_data_o;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit              m_busy [32];
   int              m_run;
   bit              m_hold;
   bit              m_last_ready;
   logic            e_en;
   logic [4:0]      e_addr;
   logic [XLEN-1:0] e_data;

   always #5 clk_i = ~clk_i;

   pipe_wb_ctl #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .pipe_wr_en_i (pipe_wr_en_i),
      .pipe_rd_i    (pipe_rd_i),
      .pipe_data_i  (pipe_data_i),
      .mdu_valid_i  (mdu_valid_i),
      .mdu_rd_i     (mdu_rd_i),
      .mdu_data_i   (mdu_data_i),
      .mdu_ready_o  (mdu_ready_o),
      .iss_en_i     (iss_en_i),
      .iss_rd_i     (iss_rd_i),
      .dec_rs1_i    (dec_rs1_i),
      .dec_rs2_i    (dec_rs2_i),
      .dec_rd_i     (dec_rd_i),
      .hazard_o     (hazard_o),
      .hold_o       (hold_o),
      .rd_wr_en_o   (rd_wr_en_o),
      .rd_wr_addr_o (rd_wr_addr_o),
      .rd_wr_data_o (rd_wr_data_o)
   );

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_run        = 0;
      m_hold       = 1'b0;
      m_last_ready = 1'b0;
      e_en         = 1'b0;
      e_addr       = 5'd0;
      e_data       = '0;
   endtask

   task automatic idle_inputs();
      pipe_wr_en_i = 1'b0; pipe_rd_i = 5'd0; pipe_data_i = '0;
      mdu_valid_i  = 1'b0; mdu_rd_i  = 5'd0; mdu_data_i  = '0;
      iss_en_i     = 1'b0; iss_rd_i  = 5'd0;
      dec_rs1_i    = 5'd0; dec_rs2_i = 5'd0; dec_rd_i = 5'd0;
   endtask

   // One clock: check combinational outputs, advance the model, check registers.
   task automatic run_cycle();
      logic exp_ready, exp_haz;
      #1;
      exp_ready = mdu_valid_i & (m_hold | ~pipe_wr_en_i);
      exp_haz   = m_busy[dec_rs1_i] | m_busy[dec_rs2_i] | m_busy[dec_rd_i];
      vectors++;
      if (mdu_ready_o !== exp_ready) begin
         miscompares++;
         $display("FAIL mdu_ready: got %b want %b @%0t", mdu_ready_o, exp_ready, $time);
      end
      vectors++;
      if (hazard_o !== exp_haz) begin
         miscompares++;
         $display("FAIL hazard: got %b want %b @%0t", hazard_o, exp_haz, $time);
      end
      if (pipe_wr_en_i && m_hold) begin
         miscompares++;
         $display("FAIL protocol: pipe write while hold asserted @%0t", $time);
      end
      @(posedge clk_i);
      if (pipe_wr_en_i && !m_hold) begin
         e_en = (pipe_rd_i != 0); e_addr = pipe_rd_i; e_data = pipe_data_i;
      end else if (exp_ready) begin
         e_en = (mdu_rd_i != 0); e_addr = mdu_rd_i; e_data = mdu_data_i;
      end else begin
         e_en = 1'b0;
      end
      if (exp_ready && mdu_rd_i != 0) m_busy[mdu_rd_i] = 1'b0;
      if (iss_en_i && iss_rd_i != 0)  m_busy[iss_rd_i] = 1'b1;
      if (!mdu_valid_i || exp_ready) begin
         m_run = 0; m_hold = 1'b0;
      end else begin
         m_run++;
         if (m_run >= STARVE_MAX) m_hold = 1'b1;
      end
      m_last_ready = exp_ready;
      #1;
      vectors++;
      if ({rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o, hold_o} !== {e_en, e_addr, e_data, m_hold}) begin
         miscompares++;
         $display("FAIL wb_regs: got en=%b addr=%0d data=%h hold=%b want en=%b addr=%0d data=%h hold=%b @%0t",
                  rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o, hold_o, e_en, e_addr, e_data, m_hold, $time);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n_i = 1'b0;
      model_reset();
      #12;
      vectors++;
      if ({rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o, hold_o, hazard_o, mdu_ready_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: en=%b addr=%0d data=%h hold=%b haz=%b rdy=%b want all 0",
                  rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o, hold_o, hazard_o, mdu_ready_o);
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      run_cycle();
   endtask

   task automatic test_pipe_only();
      idle_inputs();
      pipe_wr_en_i = 1'b1; pipe_rd_i = 5'd5; pipe_data_i = 32'hDEADBEEF;
      run_cycle();
      idle_inputs();
      vectors++;
      if ({rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         miscompares++;
         $display("FAIL pipe_only: got en=%b addr=%0d data=%h want 1/5/deadbeef",
                  rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o);
      end
      run_cycle();
   endtask

   task automatic test_x0();
      idle_inputs();
      pipe_wr_en_i = 1'b1; pipe_rd_i = 5'd0; pipe_data_i = 32'h1234;
      run_cycle();
      idle_inputs();
      vectors++;
      if ({rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o} !== {1'b0, 5'd0, 32'h1234}) begin
         miscompares++;
         $display("FAIL x0_write: got en=%b addr=%0d data=%h want 0/0/1234",
                  rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o);
      end
      iss_en_i = 1'b1; iss_rd_i = 5'd0;
      run_cycle();
      idle_inputs();
      #1;
      vectors++;
      if (hazard_o !== 1'b0) begin
         miscompares++;
         $display("FAIL x0_hazard: got %b want 0", hazard_o);
      end
      run_cycle();
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      iss_en_i = 1'b1; iss_rd_i = 5'd7;
      run_cycle();
      idle_inputs();
      dec_rs2_i = 5'd7;
      #1;
      vectors++;
      if (hazard_o !== 1'b1) begin
         miscompares++;
         $display("FAIL sb_set: hazard got %b want 1", hazard_o);
      end
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd7; mdu_data_i = 32'h55;
      #1;
      vectors++;
      if (mdu_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL sb_mdu_ready: got %b want 1", mdu_ready_o);
      end
      run_cycle();
      mdu_valid_i = 1'b0;
      #1;
      vectors++;
      if ({rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o, hazard_o} !== {1'b1, 5'd7, 32'h55, 1'b0}) begin
         miscompares++;
         $display("FAIL sb_clear: got en=%b addr=%0d data=%h haz=%b want 1/7/55/0",
                  rd_wr_en_o, rd_wr_addr_o, rd_wr_data_o, hazard_o);
      end
      run_cycle();
   endtask

   task automatic test_starvation();
      int pipe_writes = 0;
      int hold_cycle  = -1;
      bit mdu_done    = 1'b0;
      idle_inputs();
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd11; mdu_data_i = 32'hA5A5_0011;
      pipe_rd_i   = 5'd10;
      for (int i = 1; i <= 20 && !mdu_done; i++) begin
         pipe_wr_en_i = ~hold_o;
         pipe_data_i  = 32'(i);
         run_cycle();
         if (rd_wr_en_o && rd_wr_addr_o == 5'd10) pipe_writes++;
         if (hold_o && hold_cycle < 0) hold_cycle = i;
         if (rd_wr_en_o && rd_wr_addr_o == 5'd11) begin
            mdu_done    = 1'b1;
            mdu_valid_i = 1'b0;
            vectors++;
            if (hold_o !== 1'b0) begin
               miscompares++;
               $display("FAIL starve_hold_fall: hold got %b want 0", hold_o);
            end
         end
      end
      vectors++;
      if (!mdu_done) begin
         miscompares++;
         $display("FAIL starve_timeout: MDU result not written within 20 cycles");
      end
      vectors++;
      if (hold_cycle != STARVE_MAX) begin
         miscompares++;
         $display("FAIL starve_hold_rise: hold rose after cycle %0d want %0d", hold_cycle, STARVE_MAX);
      end
      vectors++;
      if (pipe_writes != STARVE_MAX) begin
         miscompares++;
         $display("FAIL starve_pipe_count: got %0d pipe writes want %0d", pipe_writes, STARVE_MAX);
      end
      idle_inputs();
      run_cycle();
   endtask

   task automatic test_set_clear();
      idle_inputs();
      iss_en_i = 1'b1; iss_rd_i = 5'd9;
      run_cycle();
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd9; mdu_data_i = 32'h99;
      run_cycle();
      idle_inputs();
      dec_rs1_i = 5'd9;
      #1;
      vectors++;
      if (hazard_o !== 1'b1) begin
         miscompares++;
         $display("FAIL set_wins: hazard got %b want 1", hazard_o);
      end
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd9; mdu_data_i = 32'h9A;
      run_cycle();
      mdu_valid_i = 1'b0;
      #1;
      vectors++;
      if (hazard_o !== 1'b0) begin
         miscompares++;
         $display("FAIL set_then_clear: hazard got %b want 0", hazard_o);
      end
      run_cycle();
   endtask

   task automatic test_reset_force();
      idle_inputs();
      iss_en_i = 1'b1; iss_rd_i = 5'd3;
      run_cycle();
      idle_inputs();
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd20; mdu_data_i = 32'hF00D;
      pipe_rd_i   = 5'd12;
      for (int i = 0; i < 10 && !hold_o; i++) begin
         pipe_wr_en_i = 1'b1;
         pipe_data_i  = 32'(i);
         run_cycle();
      end
      pipe_wr_en_i = 1'b0;
      dec_rs1_i    = 5'd3;
      vectors++;
      if (hold_o !== 1'b1) begin
         miscompares++;
         $display("FAIL force_entry: hold got %b want 1", hold_o);
      end
      rst_n_i = 1'b0;
      model_reset();
      #1;
      vectors++;
      if ({hold_o, rd_wr_en_o, hazard_o} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_in_force: hold=%b en=%b haz=%b want 000", hold_o, rd_wr_en_o, hazard_o);
      end
      #2;
      rst_n_i = 1'b1;
      // A single blocked cycle after release must not raise hold: FSM restarted in IDLE.
      pipe_wr_en_i = 1'b1; pipe_rd_i = 5'd13; pipe_data_i = 32'h13;
      run_cycle();
      pipe_wr_en_i = 1'b0;
      run_cycle();
      idle_inputs();
      run_cycle();
   endtask

   task automatic test_random();
      idle_inputs();
      for (int i = 0; i < 400; i++) begin
         if (!(mdu_valid_i && !m_last_ready)) begin
            mdu_valid_i = ($urandom_range(0, 2) == 0);
            mdu_rd_i    = 5'($urandom_range(0, 31));
            mdu_data_i  = $urandom;
         end
         pipe_wr_en_i = m_hold ? 1'b0 : ($urandom_range(0, 9) < 6);
         pipe_rd_i    = 5'($urandom_range(0, 31));
         pipe_data_i  = $urandom;
         iss_en_i     = ($urandom_range(0, 3) == 0);
         iss_rd_i     = 5'($urandom_range(0, 31));
         dec_rs1_i    = 5'($urandom_range(0, 31));
         dec_rs2_i    = 5'($urandom_range(0, 31));
         dec_rd_i     = 5'($urandom_range(0, 31));
         run_cycle();
      end
      idle_inputs();
      run_cycle();
   endtask

   initial begin
      test_reset();
      test_pipe_only();
      test_x0();
      test_scoreboard();
      test_starvation();
      test_set_clear();
      test_random();
      test_reset_force();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipe_wb_ctl.md
Name: pipe_wb_ctl

Overview:
- Write-back port controller for the hxd32 pipeline.
- Shares the single register-file write port between the in-order pipeline write-back and the long-latency multiply/divide unit (MDU).
- Keeps a per-register scoreboard of pending MDU results and drives the decode-stage hazard stall.
- Forces a pipeline hold when the MDU result has been starved for too long.

Parameters:
- XLEN, 32, data width of register write data.
- STARVE_MAX, 4, number of consecutive blocked cycles of a valid MDU result before a forced hold (range 1..15).

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  asynchronous active-low reset
- pipe_wr_en_i  input  1  pipeline requests a register write this cycle
- pipe_rd_i  input  5  pipeline destination register
- pipe_data_i  input  XLEN  pipeline write data
- mdu_valid_i  input  1  MDU result available
- mdu_rd_i  input  5  MDU destination register
- mdu_data_i  input  XLEN  MDU result data
- mdu_ready_o  output  1  MDU result accepted this cycle (combinational)
- iss_en_i  input  1  an MDU op is issued this cycle
- iss_rd_i  input  5  destination register of the issued MDU op
- dec_rs1_i  input  5  decode-stage source register 1
- dec_rs2_i  input  5  decode-stage source register 2
- dec_rd_i  input  5  decode-stage destination register
- hazard_o  output  1  decode must stall (combinational)
- hold_o  output  1  pipeline must freeze; pipeline write-back is suppressed (registered)
- rd_wr_en_o  output  1  register-file write enable (registered)
- rd_wr_addr_o  output  5  register-file write address (registered)
- rd_wr_data_o  output  XLEN  register-file write data (registered)

Behaviour:
- Clock is clk_i. Reset is asynchronous and active-low on rst_n_i.
- Reset values:
  - rd_wr_en_o=0, rd_wr_addr_o=0, rd_wr_data_o=0, hold_o=0.
  - Scoreboard is all-zero, starve counter is 0, FSM is IDLE.
- Grant: the pipeline has priority.
  - mdu_ready_o = mdu_valid_i & (state==FORCE | !pipe_wr_en_i).
  - Pipeline is granted when pipe_wr_en_i & state!=FORCE.
- Output register:
  - One-cycle latency. The granted requester's rd/data appear on rd_wr_*_o the next edge.
  - rd_wr_en_o = grant & (rd != 0). x0 is never written; its address and data still update.
  - With no grant, rd_wr_en_o=0 and addr/data hold their previous values.
- FSM states and transitions:
  - IDLE → WAIT when mdu_valid_i and blocked by the pipeline; counter is set to 1.
  - WAIT, still blocked: counter increments. When counter==STARVE_MAX and still blocked → FORCE; hold_o goes 1 on the same edge.
  - WAIT → IDLE on an MDU handshake; counter clears.
  - FORCE: mdu_ready_o=1 whenever mdu_valid_i. A pipe_wr_en_i in FORCE is a protocol violation: the write is dropped and flagged by a bench assertion.
  - FORCE → IDLE after the MDU handshake; hold_o clears on that edge.
  - Any state: mdu_valid_i low → IDLE, counter 0, hold_o 0.
- Scoreboard (32 busy bits; bit 0 is tied 0):
  - Set: iss_en_i & iss_rd_i!=0 sets busy[iss_rd_i].
  - Clear: an MDU handshake clears busy[mdu_rd_i].
  - Set and clear on the same register in the same cycle: set wins (back-to-back MDU ops).
- hazard_o = busy[dec_rs1_i] | busy[dec_rs2_i] | busy[dec_rd_i]. The rd term covers WAW. Evaluated on current register state; no bypass of the same-cycle issue.
- Counter width is 4 bits and saturates at STARVE_MAX; no wrap.
- Reset mid-operation discards the pending MDU result tracking and all busy bits. Upstream is also reset.

Decomposition:
- Shared package hxd32_pkg holds:
  - typedef reg_addr_t (5 bits)
  - REG_ZERO constant
  - wb_state_t enum {WB_IDLE, WB_WAIT, WB_FORCE}
- One natural sub-module: wb_scoreboard, holding the 32-bit busy vector with set/clear/lookup of 3 read ports.
- The grant logic, FSM and output register stay in pipe_wb_ctl.

Test Plan:
- Pipeline only: pipe_wr_en_i=1, rd=5, data=0xDEADBEEF → next cycle rd_wr_en_o=1, addr=5, data=0xDEADBEEF, mdu_ready_o never asserted.
- x0 suppression: pipe write with rd=0, data=0x1234 → rd_wr_en_o=0; MDU issue to rd=0 → hazard_o stays 0.
- Scoreboard: issue rd=7, then dec_rs2_i=7 → hazard_o=1. MDU result rd=7, data=0x55 with no pipe write → mdu_ready_o=1, written next cycle, hazard_o=0 the cycle after.
- Starvation (STARVE_MAX=4): mdu_valid_i held with pipe_wr_en_i=1 every cycle:
  - hold_o rises after the 4th blocked cycle.
  - Next cycle (pipe_wr_en_i=0) MDU is written and hold_o falls.
  - Exactly 4 pipe writes precede the MDU write.
- Simultaneous set/clear: MDU handshake on rd=9 while iss_en_i issues rd=9 → busy[9] remains 1, hazard_o=1 for dec_rs1_i=9.
- Async reset asserted while in FORCE with busy[3]=1 → hold_o=0, rd_wr_en_o=0, hazard_o=0 immediately; FSM in IDLE after release.
